// File: rtl/pipe_mdu.sv
// Iterative signed multiply/divide unit for an in-order pipeline: one
// shift-add or restoring subtract-shift step per cycle, 32 steps per operation.
module pipe_mdu (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic        div_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic        cancel_i,
   output logic        busy_o,
   output logic        ready_o,
   output logic [31:0] result_o,
   output logic [31:0] rem_o,
   output logic        dz_o
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        div_q, div_d, dz_q, dz_d, qneg_q, qneg_d, rneg_q, rneg_d;
   // acc: product (mul) / partial remainder (div); x: multiplicand / quotient;
   // y: multiplier / divisor
   logic [31:0] acc_q, acc_d, x_q, x_d, y_q, y_d;
   logic [31:0] res_q, res_d, rem_q, rem_d;
   logic        dzo_q, dzo_d;

   logic [31:0] a_mag, b_mag, fin_res, fin_rem;
   logic [32:0] rshift, rdiff;

   assign a_mag  = a_i[31] ? -a_i : a_i;
   assign b_mag  = b_i[31] ? -b_i : b_i;
   assign rshift = {acc_q, x_q[31]};
   assign rdiff  = rshift - {1'b0, y_q};

   always_comb begin
      fin_res = '0;
      fin_rem = '0;
      if (dz_q) begin
         fin_res = '1;
         fin_rem = acc_q;
      end else if (div_q) begin
         fin_res = qneg_q ? -x_q : x_q;
         fin_rem = rneg_q ? -acc_q : acc_q;
      end else begin
         fin_res = qneg_q ? -acc_q : acc_q;
      end
   end

   // Outputs show the fresh result during the ready cycle and the held copy
   // otherwise, so a cancel in DONE leaves them untouched.
   assign busy_o   = (state_q != IDLE);
   assign ready_o  = (state_q == DONE) && !cancel_i;
   assign result_o = ready_o ? fin_res : res_q;
   assign rem_o    = ready_o ? fin_rem : rem_q;
   assign dz_o     = ready_o ? dz_q    : dzo_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      dz_d    = dz_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      acc_d   = acc_q;
      x_d     = x_q;
      y_d     = y_q;
      res_d   = res_q;
      rem_d   = rem_q;
      dzo_d   = dzo_q;
      case (state_q)
         IDLE: begin
            if (start_i && !cancel_i) begin
               div_d  = div_i;
               cnt_d  = '0;
               qneg_d = a_i[31] ^ b_i[31];
               rneg_d = a_i[31];
               if (div_i && (b_i == '0)) begin
                  dz_d    = 1'b1;
                  acc_d   = a_i;
                  state_d = DONE;
               end else begin
                  dz_d    = 1'b0;
                  acc_d   = '0;
                  x_d     = a_mag;
                  y_d     = b_mag;
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            if (cancel_i) begin
               state_d = IDLE;
            end else begin
               if (div_q) begin
                  if (!rdiff[32]) begin
                     acc_d = rdiff[31:0];
                     x_d   = {x_q[30:0], 1'b1};
                  end else begin
                     acc_d = rshift[31:0];
                     x_d   = {x_q[30:0], 1'b0};
                  end
               end else begin
                  if (y_q[0]) acc_d = acc_q + x_q;
                  x_d = {x_q[30:0], 1'b0};
                  y_d = {1'b0, y_q[31:1]};
               end
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == 5'd31) state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
            if (!cancel_i) begin
               res_d = fin_res;
               rem_d = fin_rem;
               dzo_d = dz_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         div_q   <= 1'b0;
         dz_q    <= 1'b0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         acc_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         res_q   <= '0;
         rem_q   <= '0;
         dzo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         dz_q    <= dz_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         acc_q   <= acc_d;
         x_q     <= x_d;
         y_q     <= y_d;
         res_q   <= res_d;
         rem_q   <= rem_d;
         dzo_q   <= dzo_d;
      end
   end

endmodule
